// File: rtl/vlog_apb_arbiter.sv
// Round-robin APB master: shares one no-wait-state APB slave between nreq local requesters.
// One SETUP/ACCESS transfer per grant, with a registered one-cycle done pulse back to the winner.
module vlog_apb_arbiter #(
  parameter int unsigned nreq      = 2,
  parameter int unsigned vpindex   = 8,
  parameter int unsigned vnapbslv  = 16,
  parameter logic [11:0] vpaddress = 12'h800,
  parameter logic [11:0] vpmask    = 12'hFFF
) (
  input  logic                 vclk,
  input  logic                 vrst,
  input  logic [nreq-1:0]      req_valid,
  input  logic [nreq-1:0]      req_write,
  input  logic [nreq*32-1:0]   req_addr,
  input  logic [nreq*32-1:0]   req_wdata,
  output logic [nreq-1:0]      req_done,
  output logic                 req_err,
  output logic [31:0]          rsp_rdata,
  output logic [vnapbslv-1:0]  vpsel,
  output logic                 vpenable,
  output logic [31:0]          vpaddr,
  output logic                 vpwrite,
  output logic [31:0]          vpwdata,
  input  logic [31:0]          vprdata
);

  localparam int unsigned pw = (nreq > 1) ? $clog2(nreq) : 1;
  localparam logic [pw-1:0] ptr_rst = pw'(nreq - 1);

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_setup  = 2'd1,
    st_access = 2'd2,
    st_done   = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [pw-1:0]        ptr, ptr_d;
  logic [pw-1:0]        win, win_d;
  logic [pw-1:0]        gnt;
  logic [pw-1:0]        cand;
  logic                 any_req;
  logic                 sel_write;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 hit;
  logic [vnapbslv-1:0]  vpsel_d;
  logic                 vpenable_d;
  logic [31:0]          vpaddr_d;
  logic                 vpwrite_d;
  logic [31:0]          vpwdata_d;
  logic [nreq-1:0]      req_done_d;
  logic                 req_err_d;
  logic [31:0]          rsp_rdata_d;

  // Round-robin scan starting one past the last winner.
  always_comb begin
    gnt     = ptr;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= nreq; i++) begin
      cand = pw'((32'(ptr) + i) % nreq);
      if (!any_req && req_valid[cand]) begin
        gnt     = cand;
        any_req = 1'b1;
      end
    end
  end

  // Payload of the candidate winner.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < nreq; i++) begin
      if (gnt == pw'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  assign hit = ((sel_addr[31:20] ^ vpaddress) & vpmask) == 12'h000;

  // Next state and next registered outputs; APB bus idles at zero outside SETUP/ACCESS.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    win_d       = win;
    vpsel_d     = '0;
    vpenable_d  = 1'b0;
    vpaddr_d    = '0;
    vpwrite_d   = 1'b0;
    vpwdata_d   = '0;
    req_done_d  = '0;
    req_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;
    case (state)
      st_idle: begin
        if (any_req) begin
          ptr_d = gnt;
          win_d = gnt;
          if (hit) begin
            state_d          = st_setup;
            vpsel_d[vpindex] = 1'b1;
            vpaddr_d         = sel_addr;
            vpwrite_d        = sel_write;
            vpwdata_d        = sel_write ? sel_wdata : 32'h0;
          end else begin
            state_d         = st_done;
            req_done_d[gnt] = 1'b1;
            req_err_d       = 1'b1;
            rsp_rdata_d     = '0;
          end
        end
      end
      st_setup: begin
        state_d          = st_access;
        vpsel_d[vpindex] = 1'b1;
        vpenable_d       = 1'b1;
        vpaddr_d         = vpaddr;
        vpwrite_d        = vpwrite;
        vpwdata_d        = vpwdata;
      end
      st_access: begin
        state_d         = st_done;
        req_done_d[win] = 1'b1;
        rsp_rdata_d     = vpwrite ? 32'h0 : vprdata;
      end
      st_done: begin
        state_d = st_idle;
      end
      default: begin
        state_d = st_idle;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge vclk or negedge vrst) begin
    if (!vrst) begin
      state     <= st_idle;
      ptr       <= ptr_rst;
      win       <= '0;
      vpsel     <= '0;
      vpenable  <= 1'b0;
      vpaddr    <= '0;
      vpwrite   <= 1'b0;
      vpwdata   <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      win       <= win_d;
      vpsel     <= vpsel_d;
      vpenable  <= vpenable_d;
      vpaddr    <= vpaddr_d;
      vpwrite   <= vpwrite_d;
      vpwdata   <= vpwdata_d;
      req_done  <= req_done_d;
      req_err   <= req_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_vlog_apb_arbiter.sv
// Directed bench for vlog_apb_arbiter: vector table of single transfers plus
// hand-written contention, reset-abort and withdrawal sequences against a small APB slave model.
module tb_vlog_apb_arbiter;

  localparam int unsigned nreq = 2;

  logic               vclk;
  logic               vrst;
  logic [nreq-1:0]    req_valid;
  logic [nreq-1:0]    req_write;
  logic [nreq*32-1:0] req_addr;
  logic [nreq*32-1:0] req_wdata;
  logic [nreq-1:0]    req_done;
  logic               req_err;
  logic [31:0]        rsp_rdata;
  logic [15:0]        vpsel;
  logic               vpenable;
  logic [31:0]        vpaddr;
  logic               vpwrite;
  logic [31:0]        vpwdata;
  logic [31:0]        vprdata;

  int n_pass;
  int n_total;

  vlog_apb_arbiter #(
    .nreq(nreq), .vpindex(8), .vnapbslv(16), .vpaddress(12'h800), .vpmask(12'hFFF)
  ) dut (
    .vclk(vclk), .vrst(vrst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
    .vpsel(vpsel), .vpenable(vpenable), .vpaddr(vpaddr), .vpwrite(vpwrite),
    .vpwdata(vpwdata), .vprdata(vprdata)
  );

  initial begin
    vclk = 1'b0;
    forever #5 vclk = ~vclk;
  end

  // Slave model: word 0 is a register, every other word reads 5 and ignores writes.
  logic [31:0] slv_reg;
  assign vprdata = (vpaddr[19:2] == 18'h0) ? slv_reg : 32'h5;
  always @(posedge vclk or negedge vrst) begin
    if (!vrst) slv_reg <= 32'h0;
    else if (vpsel[8] && vpenable && vpwrite && vpaddr[19:2] == 18'h0) slv_reg <= vpwdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_req(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[r]        = wr;
    req_addr[32*r +: 32]  = a;
    req_wdata[32*r +: 32] = d;
    req_valid[r]        = 1'b1;
  endtask

  typedef struct {
    int          r;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  // One isolated transfer from IDLE, checked cycle by cycle through SETUP/ACCESS/DONE.
  task automatic run_vec(input vec_t v, input int n);
    logic [1:0] onehot;
    onehot = 2'b01 << v.r;
    @(negedge vclk);
    drive_req(v.r, v.wr, v.addr, v.wdata);
    @(posedge vclk); #1;
    if (!v.exp_err) begin
      chk($sformatf("v%0d_setup_vpsel", n), 64'(vpsel), 64'h100);
      chk($sformatf("v%0d_setup_vpenable", n), 64'(vpenable), 64'h0);
      chk($sformatf("v%0d_setup_vpaddr", n), 64'(vpaddr), 64'(v.addr));
      chk($sformatf("v%0d_setup_vpwrite", n), 64'(vpwrite), 64'(v.wr));
      chk($sformatf("v%0d_setup_vpwdata", n), 64'(vpwdata), v.wr ? 64'(v.wdata) : 64'h0);
      chk($sformatf("v%0d_setup_done", n), 64'(req_done), 64'h0);
      @(posedge vclk); #1;
      chk($sformatf("v%0d_access_vpsel", n), 64'(vpsel), 64'h100);
      chk($sformatf("v%0d_access_vpenable", n), 64'(vpenable), 64'h1);
      chk($sformatf("v%0d_access_vpaddr", n), 64'(vpaddr), 64'(v.addr));
      @(posedge vclk); #1;
    end else begin
      chk($sformatf("v%0d_miss_vpsel", n), 64'(vpsel), 64'h0);
      chk($sformatf("v%0d_miss_vpenable", n), 64'(vpenable), 64'h0);
    end
    chk($sformatf("v%0d_done_pulse", n), 64'(req_done), 64'(onehot));
    chk($sformatf("v%0d_done_err", n), 64'(req_err), 64'(v.exp_err));
    chk($sformatf("v%0d_done_rdata", n), 64'(rsp_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d_done_vpsel", n), 64'(vpsel), 64'h0);
    chk($sformatf("v%0d_done_vpaddr", n), 64'(vpaddr), 64'h0);
    req_valid = '0;
    @(posedge vclk); #1;
    chk($sformatf("v%0d_post_done", n), 64'(req_done), 64'h0);
    chk($sformatf("v%0d_post_err", n), 64'(req_err), 64'h0);
    chk($sformatf("v%0d_post_rdata_hold", n), 64'(rsp_rdata), 64'(v.exp_rdata));
  endtask

  initial begin
    int          cnt;
    int          order [4];
    int          when [4];
    logic [31:0] rdat [4];
    int          d0;
    int          d1;
    int          d0_when;
    int          first_when;
    logic [1:0]  first_done;

    n_pass    = 0;
    n_total   = 0;
    vrst      = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    vecs[0] = '{0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{0, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h8000_0004, 32'h0000_0000, 32'h0000_0005, 1'b0};
    vecs[3] = '{0, 1'b0, 32'h9000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{1, 1'b1, 32'h8000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[5] = '{1, 1'b0, 32'h8000_0010, 32'h0000_0000, 32'h0000_0005, 1'b0};
    vecs[6] = '{1, 1'b1, 32'h8000_0000, 32'hA5A5_0F0F, 32'h0000_0000, 1'b0};
    vecs[7] = '{0, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'hA5A5_0F0F, 1'b0};
    vecs[8] = '{1, 1'b0, 32'h7FF0_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[9] = '{0, 1'b0, 32'h800F_FFFC, 32'h0000_0000, 32'h0000_0005, 1'b0};

    // Reset state
    #1;
    chk("rst_vpsel", 64'(vpsel), 64'h0);
    chk("rst_vpenable", 64'(vpenable), 64'h0);
    chk("rst_vpaddr", 64'(vpaddr), 64'h0);
    chk("rst_req_done", 64'(req_done), 64'h0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("rst_req_err", 64'(req_err), 64'h0);
    repeat (2) @(negedge vclk);
    vrst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Contention: both requesters valid out of reset -> 0,1,0,1 spaced 4 cycles
    @(negedge vclk);
    vrst = 1'b0;
    drive_req(0, 1'b0, 32'h8000_0004, 32'h0);
    drive_req(1, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge vclk);
    vrst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(posedge vclk); #1;
      if (req_done != 2'b00) begin
        order[cnt] = (req_done == 2'b01) ? 0 : ((req_done == 2'b10) ? 1 : 9);
        when[cnt]  = c;
        rdat[cnt]  = rsp_rdata;
        cnt++;
        if (cnt == 4) req_valid = '0;
      end
    end
    chk("cont_count", 64'(cnt), 64'd4);
    if (cnt > 0) chk("cont_first_latency", 64'(when[0]), 64'd2);
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("cont_order%0d", i), 64'(order[i]), 64'(i % 2));
      chk($sformatf("cont_rdata%0d", i), 64'(rdat[i]), (i % 2 == 0) ? 64'h5 : 64'h0);
    end
    for (int i = 1; i < cnt; i++)
      chk($sformatf("cont_spacing%0d", i), 64'(when[i] - when[i-1]), 64'd4);
    repeat (2) @(posedge vclk);

    // Reset during ACCESS: transfer abandoned, requester 0 served first afterwards
    @(negedge vclk);
    drive_req(0, 1'b0, 32'h8000_0000, 32'h0);
    @(posedge vclk); #1;
    @(posedge vclk); #1;
    chk("rmid_pre_access", 64'(vpenable), 64'h1);
    vrst = 1'b0;
    drive_req(1, 1'b0, 32'h8000_0004, 32'h0);
    #1;
    chk("rmid_vpsel", 64'(vpsel), 64'h0);
    chk("rmid_vpenable", 64'(vpenable), 64'h0);
    chk("rmid_req_done", 64'(req_done), 64'h0);
    chk("rmid_vpaddr", 64'(vpaddr), 64'h0);
    for (int c = 0; c < 2; c++) begin
      @(posedge vclk); #1;
      chk($sformatf("rmid_held_done%0d", c), 64'(req_done), 64'h0);
    end
    @(negedge vclk);
    vrst = 1'b1;
    first_when = -1;
    first_done = 2'b00;
    for (int c = 0; c < 12 && first_when < 0; c++) begin
      @(posedge vclk); #1;
      if (req_done != 2'b00) begin
        first_when = c;
        first_done = req_done;
        req_valid  = '0;
      end
    end
    chk("rmid_first_seen", 64'(first_when >= 0), 64'h1);
    chk("rmid_first_winner", 64'(first_done), 64'h1);
    chk("rmid_first_latency", 64'(first_when), 64'd2);
    repeat (2) @(posedge vclk);

    // Withdrawal: req1 pulses valid for one cycle while req0 is in flight
    @(negedge vclk);
    drive_req(0, 1'b0, 32'h8000_0004, 32'h0);
    @(posedge vclk); #1;
    drive_req(1, 1'b0, 32'h8000_0000, 32'h0);
    @(posedge vclk); #1;
    req_valid[1] = 1'b0;
    d0 = 0;
    d1 = 0;
    d0_when = -1;
    for (int c = 0; c < 12; c++) begin
      if (req_done[0]) begin
        d0++;
        if (d0_when < 0) d0_when = c;
        req_valid[0] = 1'b0;
      end
      if (req_done[1]) d1++;
      @(posedge vclk); #1;
    end
    chk("wd_req0_dones", 64'(d0), 64'd1);
    chk("wd_req0_latency", 64'(d0_when), 64'd1);
    chk("wd_req1_dones", 64'(d1), 64'd0);
    chk("wd_idle_vpsel", 64'(vpsel), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
